pn_spread_ctrl: RTL and testbench
=================================

PN_SPREAD_CTRL -- requirements
Module: pn_spread_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the clock port SHALL be named clk and the reset port rst.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the PN ROM address width.
REQ-003 Parameter FIFO_DEPTH, default 2, SHALL set the output chip buffer depth.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 enable  in  1  run request; level-sensitive.
REQ-007 len_m1  in  ADDR_WIDTH  PN period minus one; latched on IDLE->RUN.
REQ-008 sym_valid / sym_data / sym_ready  in 1 / in 1 / out 1  symbol input handshake.
REQ-009 rom_ena / rom_addr  out 1 / out ADDR_WIDTH  PN ROM read strobe and address.
REQ-010 rom_data / rom_valid  in 1 / in 1  PN ROM chip, valid exactly one cycle after the rom_ena cycle.
REQ-011 chip_valid / chip_data / chip_last / chip_ready  out 1 / out 1 / out 1 / in 1  spread-chip output handshake.
REQ-012 busy  out 1  high in any state other than IDLE.

Function
REQ-013 States SHALL be IDLE, RUN and DRAIN.
REQ-014 IDLE->RUN when enable=1; RUN->DRAIN when enable=0 and no symbol is held; DRAIN->IDLE when no read is in flight and the FIFO is empty.
REQ-015 Transfers SHALL occur only on valid&ready at a rising edge; chip_valid and chip_data SHALL be held stable while chip_ready=0.
REQ-016 sym_ready SHALL be 1 only in RUN with enable=1, and only when no symbol is held or the held symbol's final address is issued in that cycle.
REQ-017 Each accepted symbol SHALL issue addresses 0..len_m1 in order; after len_m1 the address SHALL wrap to 0 for the next symbol.
REQ-018 rom_ena SHALL be 1 only when a symbol is held and (FIFO occupancy + in-flight reads - pop this cycle) < FIFO_DEPTH.
REQ-019 chip_data SHALL equal rom_data XOR the symbol bit of the issuing read; chip_last SHALL be 1 for the chip read from address len_m1.
REQ-020 The symbol bit and last flag SHALL be pipelined alongside each read so that a symbol change between issue and return does not corrupt data.
REQ-021 First chip_valid SHALL occur three cycles after the accepting edge; with chip_ready=1 and sym_valid=1 the output SHALL sustain one chip per cycle with no bubble between symbols.
REQ-022 len_m1=0 SHALL give one chip per symbol with chip_last=1 on every chip.
REQ-023 A change of len_m1 while busy=1 SHALL be ignored until the next IDLE->RUN.
REQ-024 Deasserting enable mid-symbol SHALL let the held symbol complete all chips; no further symbol SHALL be accepted.
REQ-025 rom_valid arriving with no read in flight SHALL be discarded.

Reset
REQ-026 While rst=1 at an edge: state=IDLE; address, in-flight count and FIFO cleared; sym_ready, rom_ena, chip_valid, chip_data, chip_last and busy SHALL be 0 in the following cycle.
REQ-027 Reset mid-symbol SHALL abandon the symbol and drop buffered chips without emitting them.

Structure
REQ-028 Package pn_ctrl_pkg SHALL hold the state enum, the default ADDR_WIDTH and the default FIFO_DEPTH.
REQ-029 The output buffer SHALL be a sub-module chip_fifo (width 2: data and last; depth FIFO_DEPTH; synchronous reset).

Verification
REQ-030 len_m1=7, ROM pattern 10110010, symbols 0 then 1, chip_ready=1 -> chips 10110010 then 01001101, chip_last on chips 8 and 16, no gaps.
REQ-031 chip_ready toggled pseudo-randomly, 100 symbols -> no chip lost or duplicated; stalled outputs stable; rom_ena never exceeds the credit limit.
REQ-032 len_m1=0, 5 symbols -> 5 chips, each with chip_last=1.
REQ-033 enable dropped at chip 3 of 8 -> remaining 5 chips emitted; sym_ready stays 0; busy falls after the last chip pops.
REQ-034 rst pulsed at chip 4 -> next cycle all outputs 0; a new symbol after reset restarts at address 0.
REQ-035 len_m1 changed from 7 to 3 mid-run -> period stays 8 until IDLE; after re-enable the period is 4.

Source files
------------

// File: rtl/pn_ctrl_pkg.sv
// rtl/pn_ctrl_pkg.sv - shared defaults and state encoding for the PN spreading controller
package pn_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_FIFO_DEPTH = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        PN_IDLE  = ST_IDLE,
        PN_RUN   = ST_RUN,
        PN_DRAIN = ST_DRAIN
    } pn_state_e;

endpackage

// File: rtl/chip_fifo.sv
// rtl/chip_fifo.sv - small output buffer holding {last, data} chip pairs
module chip_fifo #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [1:0]    push_data,
    input  logic          pop,
    output logic          valid,
    output logic [1:0]    data,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    // Head is forced to zero when empty so idle outputs read as 0.
    assign data   = valid ? mem[rd_ptr] : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 2'b00;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pn_spread_ctrl.sv
// rtl/pn_spread_ctrl.sv - spreads input symbols with a PN ROM sequence into a chip stream
module pn_spread_ctrl
    import pn_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] len_m1,
    input  logic                  sym_valid,
    input  logic                  sym_data,
    output logic                  sym_ready,
    output logic                  rom_ena,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_data,
    input  logic                  rom_valid,
    output logic                  chip_valid,
    output logic                  chip_data,
    output logic                  chip_last,
    input  logic                  chip_ready,
    output logic                  busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]           DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  held;
    logic                  sym_bit;
    logic                  inflight;
    logic                  fl_sym;
    logic                  fl_last;
    logic [CW-1:0]         occ;
    logic [CW:0]           used;
    logic [1:0]            head;
    logic                  at_last;
    logic                  pop;
    logic                  push;
    logic                  accept;

    assign at_last  = (addr == len_q);
    assign pop      = chip_valid && chip_ready;
    // Credit: buffered chips plus the read still returning, minus what leaves now.
    assign used     = {1'b0, occ} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign rom_ena  = held && (used < DEPTH_LIM);
    assign rom_addr = addr;
    assign sym_ready = (state == ST_RUN) && enable && (!held || (rom_ena && at_last));
    assign accept   = sym_valid && sym_ready;
    // A returning chip is only taken when we actually issued a read last cycle.
    assign push     = rom_valid && inflight;
    assign busy     = (state != ST_IDLE);
    assign chip_data = head[0];
    assign chip_last = head[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            addr     <= '0;
            held     <= 1'b0;
            sym_bit  <= 1'b0;
            inflight <= 1'b0;
            fl_sym   <= 1'b0;
            fl_last  <= 1'b0;
        end else begin
            inflight <= rom_ena;
            if (rom_ena) begin
                fl_sym  <= sym_bit;
                fl_last <= at_last;
                addr    <= at_last ? '0 : addr + ADDR_ONE;
            end
            if (accept) begin
                held    <= 1'b1;
                sym_bit <= sym_data;
            end else if (rom_ena && at_last) begin
                held <= 1'b0;
            end
            case (state)
                ST_IDLE: if (enable) begin
                    state <= ST_RUN;
                    len_q <= len_m1;
                    addr  <= '0;
                end
                ST_RUN: if (!enable && !held) begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: if (!inflight && !chip_valid) begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    chip_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_chip_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({fl_last, rom_data ^ fl_sym}),
        .pop       (pop),
        .valid     (chip_valid),
        .data      (head),
        .count     (occ)
    );

endmodule

// File: tb/tb_pn_spread_ctrl.sv
// tb/tb_pn_spread_ctrl.sv - randomized self-checking bench for pn_spread_ctrl
module tb_pn_spread_ctrl;
    localparam int AW = 10;
    localparam int FD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] len_m1 = '0;
    logic          sym_valid = 1'b0;
    logic          sym_data = 1'b0;
    logic          sym_ready;
    logic          rom_ena;
    logic [AW-1:0] rom_addr;
    logic          rom_data = 1'b0;
    logic          rom_valid = 1'b0;
    logic          chip_valid;
    logic          chip_data;
    logic          chip_last;
    logic          chip_ready = 1'b1;
    logic          busy;

    pn_spread_ctrl #(.ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .len_m1     (len_m1),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .rom_ena    (rom_ena),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_valid  (rom_valid),
        .chip_valid (chip_valid),
        .chip_data  (chip_data),
        .chip_last  (chip_last),
        .chip_ready (chip_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ROM responder: answers one cycle after each rom_ena cycle, optionally injects stray valids.
    bit            rom_mem [1024];
    logic          last_ena = 1'b0;
    logic [AW-1:0] last_addr = '0;
    bit            inject = 1'b0;
    int            ready_mode = 0;

    always @(negedge clk) begin
        last_ena  = rom_ena;
        last_addr = rom_addr;
    end

    always @(posedge clk) begin
        #1;
        if (last_ena) begin
            rom_valid = 1'b1;
            rom_data  = rom_mem[last_addr];
        end else if (inject && $urandom_range(0, 3) == 0) begin
            rom_valid = 1'b1;
            rom_data  = 1'($urandom_range(0, 1));
        end else begin
            rom_valid = 1'b0;
            rom_data  = 1'($urandom_range(0, 1));
        end
        chip_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Reference model: each accepted symbol expands to model_len+1 chips rom[a]^sym.
    bit   q_exp[$];
    bit   q_last[$];
    bit   got_bits[$];
    int   last_idx[$];
    int   model_len = 0;
    int   outstanding = 0;
    bit   prev_stall = 1'b0;
    logic [1:0] prev_out = 2'b00;
    int   n_chips = 0;
    int   n_lasts = 0;
    int   first_pop_cyc = 0;
    int   last_pop_cyc = 0;
    int   first_valid_cyc = -1;
    int   accept_cyc = -1;

    always @(negedge clk) begin
        bit pop_now;
        bit e;
        bit l;
        if (rst) begin
            q_exp.delete();
            q_last.delete();
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            pop_now = chip_valid && chip_ready;
            if (prev_stall) begin
                check("stall_valid", chip_valid, 1);
                check("stall_hold", {chip_last, chip_data}, prev_out);
            end
            if (!enable) check("sym_ready_off", sym_ready, 0);
            if (sym_valid && sym_ready) begin
                if (accept_cyc < 0) accept_cyc = cyc;
                for (int a = 0; a <= model_len; a++) begin
                    q_exp.push_back(rom_mem[a] ^ sym_data);
                    q_last.push_back(a == model_len);
                end
            end
            if (chip_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rom_ena) check("credit", (outstanding - int'(pop_now)) < FD, 1);
            if (pop_now) begin
                if (q_exp.size() == 0) begin
                    check("extra_chip", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    l = q_last.pop_front();
                    check("chip_data", chip_data, e);
                    check("chip_last", chip_last, l);
                end
                if (n_chips == 0) first_pop_cyc = cyc;
                if (chip_last) begin
                    n_lasts++;
                    last_idx.push_back(n_chips);
                end
                got_bits.push_back(chip_data);
                n_chips++;
                last_pop_cyc = cyc;
            end
            outstanding += int'(rom_ena) - int'(pop_now);
            prev_stall = chip_valid && !chip_ready;
            prev_out   = {chip_last, chip_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_bits.delete();
        last_idx.delete();
        n_chips = 0;
        n_lasts = 0;
        first_valid_cyc = -1;
        accept_cyc = -1;
    endtask

    task automatic start_run(input int len);
        len_m1    = AW'(len);
        model_len = len;
        enable    = 1'b1;
    endtask

    task automatic feed(input int n, input logic [31:0] bits, input bit fixed);
        int sent = 0;
        int guard = 0;
        bit acc;
        sym_valid = 1'b1;
        sym_data  = fixed ? bits[0] : 1'($urandom_range(0, 1));
        while (sent < n && guard < 20000) begin
            @(negedge clk);
            acc = sym_ready;
            tick();
            guard++;
            if (acc) begin
                sent++;
                if (sent < n) sym_data = fixed ? bits[sent] : 1'($urandom_range(0, 1));
                else sym_valid = 1'b0;
            end
        end
        sym_valid = 1'b0;
        check("feed_done", sent, n);
    endtask

    task automatic wait_idle();
        int guard = 0;
        enable    = 1'b0;
        sym_valid = 1'b0;
        while (busy && guard < 5000) begin
            tick();
            guard++;
        end
        check("idle_reached", busy, 0);
        check("queue_empty", q_exp.size(), 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        enable = 1'b0;
        sym_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  pat;
        logic [15:0] g;
        int guard;
        int fall_cyc;

        // Reset state
        do_reset(2);
        check("reset_outputs", {sym_ready, rom_ena, chip_valid, chip_data, chip_last, busy}, 0);

        // Known pattern, symbols 0 then 1
        pat = 8'b10110010;
        for (int i = 0; i < 8; i++) rom_mem[i] = pat[7-i];
        ready_mode = 0;
        clear_log();
        start_run(7);
        feed(2, 32'b10, 1'b1);
        wait_idle();
        check("pat_count", n_chips, 16);
        g = '0;
        foreach (got_bits[i]) g = {g[14:0], got_bits[i]};
        check("pat_bits", g, 16'b1011001001001101);
        check("pat_lasts", n_lasts, 2);
        if (n_lasts == 2) begin
            check("pat_last0", last_idx[0], 7);
            check("pat_last1", last_idx[1], 15);
        end
        check("pat_no_gap", last_pop_cyc - first_pop_cyc, 15);
        check("first_latency", first_valid_cyc - accept_cyc, 3);

        // Single-chip period
        for (int i = 0; i < 16; i++) rom_mem[i] = 1'($urandom_range(0, 1));
        clear_log();
        start_run(0);
        feed(5, 0, 1'b0);
        wait_idle();
        check("len0_count", n_chips, 5);
        check("len0_lasts", n_lasts, 5);

        // Enable dropped mid-symbol
        clear_log();
        start_run(7);
        sym_valid = 1'b1;
        sym_data  = 1'($urandom_range(0, 1));
        guard = 0;
        while (n_chips < 3 && guard < 200) begin tick(); guard++; end
        check("drop_reach3", n_chips >= 3, 1);
        enable = 1'b0;
        guard = 0;
        while (busy && guard < 500) begin tick(); guard++; end
        fall_cyc = cyc;
        sym_valid = 1'b0;
        check("drop_idle", busy, 0);
        check("drop_count", n_chips, 8);
        check("drop_busy_after", fall_cyc > last_pop_cyc, 1);
        check("drop_queue", q_exp.size(), 0);

        // Reset in the middle of a symbol
        clear_log();
        start_run(7);
        feed(1, 0, 1'b0);
        guard = 0;
        while (n_chips < 4 && guard < 200) begin tick(); guard++; end
        check("rst_reach4", n_chips, 4);
        rst = 1'b1;
        enable = 1'b0;
        tick();
        check("rst_outputs", {sym_ready, rom_ena, chip_valid, chip_data, chip_last, busy}, 0);
        rst = 1'b0;
        repeat (6) tick();
        check("rst_no_more", n_chips, 4);
        clear_log();
        start_run(7);
        sym_valid = 1'b1;
        sym_data  = 1'($urandom_range(0, 1));
        guard = 0;
        while (!rom_ena && guard < 50) begin tick(); guard++; end
        sym_valid = 1'b0;
        check("rst_restart_ena", rom_ena, 1);
        check("rst_restart_addr", rom_addr, 0);
        wait_idle();
        check("rst_restart_count", n_chips, 8);

        // Length change ignored while busy
        clear_log();
        start_run(7);
        feed(1, 0, 1'b0);
        len_m1 = AW'(3);
        feed(2, 0, 1'b0);
        wait_idle();
        check("len_hold_count", n_chips, 24);
        clear_log();
        start_run(3);
        feed(3, 0, 1'b0);
        wait_idle();
        check("len_new_count", n_chips, 12);

        // Random back-pressure, stray ROM valids, 100 symbols
        for (int i = 0; i < 16; i++) rom_mem[i] = 1'($urandom_range(0, 1));
        ready_mode = 1;
        inject = 1'b1;
        clear_log();
        start_run(5);
        feed(100, 0, 1'b0);
        wait_idle();
        inject = 1'b0;
        ready_mode = 0;
        check("rand_count", n_chips, 600);
        check("rand_lasts", n_lasts, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
